alpctl_seq: RTL and testbench

ALPCTL_SEQ -- requirements
Module: alpctl_seq

---
 rtl/alpctl_pkg.sv | 42 ++++
 rtl/alpctl_dec.sv | 21 ++
 rtl/alpctl_seq.sv | 140 ++++++++++++++
 tb/tb_alpctl_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpctl_pkg.sv
// Shared types and constants for the ALPCTL sequencer: FSM states, opcode
// field positions with their match values, and per-slice idle output levels.
package alpctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int unsigned OPC_W = 10;

  // Data-move: opc[6:5] selects the move group, opc[3:0] the move code.
  localparam int unsigned DM_SEL_HI    = 6;
  localparam int unsigned DM_SEL_LO    = 5;
  localparam logic [1:0]  DM_SEL_MATCH = 2'b10;
  localparam int unsigned DM_LOW_HI    = 3;
  localparam int unsigned DM_LOW_LO    = 0;
  localparam logic [3:0]  DM_LOW_MATCH = 4'b0111;

  localparam int unsigned INH_BIT       = 4;
  localparam int unsigned INH_LOW_HI    = 1;
  localparam int unsigned INH_LOW_LO    = 0;
  localparam logic [1:0]  INH_LOW_MATCH = 2'b11;

  localparam int unsigned PA_HI    = 9;
  localparam int unsigned PA_LO    = 6;
  localparam logic [3:0]  PA_MATCH = 4'b1001;
  localparam int unsigned PA_BIT_A = 3;
  localparam int unsigned PA_BIT_B = 1;

  localparam int unsigned WM_BIT   = 9;
  localparam int unsigned WM_HI    = 7;
  localparam int unsigned WM_LO    = 5;
  localparam logic [2:0]  WM_MATCH = 3'b011;

  localparam logic IDLE_DMOVE      = 1'b0;
  localparam logic IDLE_PASS_A     = 1'b0;
  localparam logic IDLE_WMUX_OE    = 1'b0;
  localparam logic IDLE_DREG_INH_L = 1'b1;

endpackage

// File: rtl/alpctl_dec.sv
// Combinational ALPCTL opcode decoder: 10-bit opcode in, four control flags out.
module alpctl_dec
  import alpctl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output logic             dmove,
  output logic             inh,
  output logic             pass_a,
  output logic             wmux_oe
);

  always_comb begin
    dmove   = (opc[DM_SEL_HI:DM_SEL_LO] == DM_SEL_MATCH) &&
              (opc[DM_LOW_HI:DM_LOW_LO] == DM_LOW_MATCH);
    inh     = dmove && !opc[INH_BIT] &&
              (opc[INH_LOW_HI:INH_LOW_LO] == INH_LOW_MATCH);
    pass_a  = (opc[PA_HI:PA_LO] == PA_MATCH) && opc[PA_BIT_A] && opc[PA_BIT_B];
    wmux_oe = !(opc[WM_BIT] && (opc[WM_HI:WM_LO] == WM_MATCH));
  end

endmodule

// File: rtl/alpctl_seq.sv
// ALPCTL opcode sequencer: accepts an opcode, drives per-slice decode for
// rep_h+1 cycles with stall/hold support. Parity check via ALPCTL_SEQ_PARITY_EN.
module alpctl_seq
  import alpctl_pkg::*;
#(
  parameter int unsigned NSLICE = 4,
  parameter int unsigned REP_W  = 4
) (
  input  logic              clk_h,
  input  logic              reset_h,
  input  logic              opc_valid_h,
  input  logic [OPC_W-1:0]  opc_h,
  input  logic              opc_par_h,
  input  logic [REP_W-1:0]  rep_h,
  input  logic [NSLICE-1:0] slice_mask_h,
  input  logic              stall_h,
  output logic              opc_ready_h,
  output logic [NSLICE-1:0] dmove_h,
  output logic [NSLICE-1:0] wmux_oe_h,
  output logic [NSLICE-1:0] pass_a_h,
  output logic [NSLICE-1:0] dreg_inh_l,
  output logic              busy_h,
  output logic              last_h,
  output logic              perr_h
);

  state_e            state_q, state_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;
  logic [NSLICE-1:0] dmove_q, dmove_d, wmux_oe_q, wmux_oe_d;
  logic [NSLICE-1:0] pass_a_q, pass_a_d, dreg_inh_l_q, dreg_inh_l_d;
  logic              busy_q, busy_d, last_q, last_d, perr_q, perr_d;
  logic              dec_dmove, dec_inh, dec_pass_a, dec_wmux_oe;
  logic              par_bad, accept;
  logic [NSLICE-1:0] eff_mask;

  alpctl_dec u_dec (
    .opc     (opc_h),
    .dmove   (dec_dmove),
    .inh     (dec_inh),
    .pass_a  (dec_pass_a),
    .wmux_oe (dec_wmux_oe)
  );

`ifdef ALPCTL_SEQ_PARITY_EN
  assign par_bad = ~(^{opc_h, opc_par_h});
`else
  logic unused_par;
  assign unused_par = opc_par_h;
  assign par_bad    = 1'b0;
`endif

  assign opc_ready_h = (state_q == ST_IDLE) ||
                       ((state_q == ST_RUN) && last_q && !stall_h);
  assign accept      = opc_valid_h && opc_ready_h;
  assign eff_mask    = par_bad ? '0 : slice_mask_h;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmove_d      = dmove_q;
    wmux_oe_d    = wmux_oe_q;
    pass_a_d     = pass_a_q;
    dreg_inh_l_d = dreg_inh_l_q;
    busy_d       = busy_q;
    last_d       = last_q;
    perr_d       = perr_q;

    // Leaving HOLD with stall low is itself a productive cycle, so the
    // counter advances on that edge just as it would in RUN.
    case (state_q)
      ST_IDLE: ;
      ST_RUN, ST_HOLD: begin
        if (stall_h) begin
          state_d = ST_HOLD;
        end else if (cnt_q != '0) begin
          state_d = ST_RUN;
          cnt_d   = cnt_q - REP_W'(1);
          last_d  = (cnt_d == '0);
        end else begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          dmove_d      = {NSLICE{IDLE_DMOVE}};
          wmux_oe_d    = {NSLICE{IDLE_WMUX_OE}};
          pass_a_d     = {NSLICE{IDLE_PASS_A}};
          dreg_inh_l_d = {NSLICE{IDLE_DREG_INH_L}};
          busy_d       = 1'b0;
          last_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible from IDLE or an unstalled final RUN cycle,
    // so loading here overrides the finish path for back-to-back ops.
    if (accept) begin
      state_d      = ST_RUN;
      cnt_d        = rep_h;
      dmove_d      = {NSLICE{dec_dmove}} & eff_mask;
      wmux_oe_d    = {NSLICE{dec_wmux_oe}} & eff_mask;
      pass_a_d     = {NSLICE{dec_pass_a}} & eff_mask;
      dreg_inh_l_d = ~({NSLICE{dec_inh}} & eff_mask);
      busy_d       = 1'b1;
      last_d       = (rep_h == '0);
      perr_d       = perr_q || par_bad;
    end
  end

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dmove_q      <= {NSLICE{IDLE_DMOVE}};
      wmux_oe_q    <= {NSLICE{IDLE_WMUX_OE}};
      pass_a_q     <= {NSLICE{IDLE_PASS_A}};
      dreg_inh_l_q <= {NSLICE{IDLE_DREG_INH_L}};
      busy_q       <= 1'b0;
      last_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmove_q      <= dmove_d;
      wmux_oe_q    <= wmux_oe_d;
      pass_a_q     <= pass_a_d;
      dreg_inh_l_q <= dreg_inh_l_d;
      busy_q       <= busy_d;
      last_q       <= last_d;
      perr_q       <= perr_d;
    end
  end

  assign dmove_h    = dmove_q;
  assign wmux_oe_h  = wmux_oe_q;
  assign pass_a_h   = pass_a_q;
  assign dreg_inh_l = dreg_inh_l_q;
  assign busy_h     = busy_q;
  assign last_h     = last_q;
  assign perr_h     = perr_q;

endmodule

// File: tb/tb_alpctl_seq.sv
// Self-checking bench for alpctl_seq: per-cycle expected outputs are queued
// at opcode offer time and popped as the sequencer runs.
module tb_alpctl_seq;

  logic       clk_h = 1'b0;
  logic       reset_h;
  logic       opc_valid_h;
  logic [9:0] opc_h;
  logic       opc_par_h;
  logic [3:0] rep_h;
  logic [3:0] slice_mask_h;
  logic       stall_h;
  logic       opc_ready_h;
  logic [3:0] dmove_h, wmux_oe_h, pass_a_h, dreg_inh_l;
  logic       busy_h, last_h, perr_h;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_v;

  localparam logic [17:0] IDLE_V = {4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0};

  always #5 clk_h = ~clk_h;

  alpctl_seq #(.NSLICE(4), .REP_W(4)) dut (
    .clk_h        (clk_h),
    .reset_h      (reset_h),
    .opc_valid_h  (opc_valid_h),
    .opc_h        (opc_h),
    .opc_par_h    (opc_par_h),
    .rep_h        (rep_h),
    .slice_mask_h (slice_mask_h),
    .stall_h      (stall_h),
    .opc_ready_h  (opc_ready_h),
    .dmove_h      (dmove_h),
    .wmux_oe_h    (wmux_oe_h),
    .pass_a_h     (pass_a_h),
    .dreg_inh_l   (dreg_inh_l),
    .busy_h       (busy_h),
    .last_h       (last_h),
    .perr_h       (perr_h)
  );

  // Output vector order: dmove, wmux_oe, pass_a, dreg_inh_l, last, busy.
  function automatic logic [17:0] model_vec(logic [9:0] opc, logic [3:0] mask, logic last);
    logic dm, inh, pa, wm;
    dm  = (opc & 10'h06F) == 10'h047;
    inh = dm && ((opc & 10'h013) == 10'h003);
    pa  = (opc & 10'h3CA) == 10'h24A;
    wm  = !((opc & 10'h2E0) == 10'h260);
    return {{4{dm}} & mask, {4{wm}} & mask, {4{pa}} & mask, ~({4{inh}} & mask), last, 1'b1};
  endfunction

  function automatic logic [17:0] act_vec();
    return {dmove_h, wmux_oe_h, pass_a_h, dreg_inh_l, last_h, busy_h};
  endfunction

  function automatic logic good_par(logic [9:0] opc);
    return ~(^opc);
  endfunction

  task automatic offer(logic [9:0] opc, logic [3:0] mask, logic [3:0] rep, logic par);
    opc_valid_h  = 1'b1;
    opc_h        = opc;
    slice_mask_h = mask;
    rep_h        = rep;
    opc_par_h    = par;
  endtask

  task automatic idle_in();
    opc_valid_h  = 1'b0;
    opc_h        = '0;
    slice_mask_h = '0;
    rep_h        = '0;
    opc_par_h    = 1'b0;
  endtask

  task automatic push_op(logic [9:0] opc, logic [3:0] mask, logic [3:0] rep);
    for (int k = 0; k <= int'(rep); k++)
      sb.push_back(model_vec(opc, mask, k == int'(rep)));
  endtask

  task automatic test_reset();
    reset_h = 1'b1;
    stall_h = 1'b0;
    idle_in();
    repeat (2) @(negedge clk_h);
    n_checks++;
    if (act_vec() !== IDLE_V) $display("FAIL reset_outs act=%h exp=%h", act_vec(), IDLE_V);
    else n_pass++;
    n_checks++;
    if (perr_h !== 1'b0) $display("FAIL reset_perr act=%b exp=0", perr_h);
    else n_pass++;
    reset_h = 1'b0;
    @(negedge clk_h);
    n_checks++;
    if ({opc_ready_h, act_vec()} !== {1'b1, IDLE_V})
      $display("FAIL reset_release act=%h exp=%h", {opc_ready_h, act_vec()}, {1'b1, IDLE_V});
    else n_pass++;
  endtask

  task automatic test_single();
    offer(10'h047, 4'hF, 4'd0, good_par(10'h047));
    push_op(10'h047, 4'hF, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if (act_vec() !== exp_v) $display("FAIL single_op act=%h exp=%h", act_vec(), exp_v);
    else n_pass++;
    n_checks++;
    if ({dmove_h, dreg_inh_l, wmux_oe_h, pass_a_h, last_h} !== {4'hF, 4'h0, 4'hF, 4'h0, 1'b1})
      $display("FAIL single_literal act=%h exp=%h",
               {dmove_h, dreg_inh_l, wmux_oe_h, pass_a_h, last_h}, {4'hF, 4'h0, 4'hF, 4'h0, 1'b1});
    else n_pass++;
    @(negedge clk_h);
    n_checks++;
    if (act_vec() !== IDLE_V) $display("FAIL single_idle act=%h exp=%h", act_vec(), IDLE_V);
    else n_pass++;
  endtask

  task automatic test_pass_a();
    offer(10'h24A, 4'h5, 4'd2, good_par(10'h24A));
    push_op(10'h24A, 4'h5, 4'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_h);
      idle_in();
      exp_v = sb.pop_front();
      n_checks++;
      if (act_vec() !== exp_v) $display("FAIL pass_a_c%0d act=%h exp=%h", i, act_vec(), exp_v);
      else n_pass++;
      n_checks++;
      if (opc_ready_h !== (i == 2)) $display("FAIL pass_a_ready%0d act=%b exp=%b", i, opc_ready_h, i == 2);
      else n_pass++;
    end
    @(negedge clk_h);
    n_checks++;
    if (act_vec() !== IDLE_V) $display("FAIL pass_a_idle act=%h exp=%h", act_vec(), IDLE_V);
    else n_pass++;
    offer(10'h260, 4'hF, 4'd0, good_par(10'h260));
    push_op(10'h260, 4'hF, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if (act_vec() !== exp_v) $display("FAIL wmux_op act=%h exp=%h", act_vec(), exp_v);
    else n_pass++;
    n_checks++;
    if (wmux_oe_h !== 4'h0) $display("FAIL wmux_off act=%h exp=0", wmux_oe_h);
    else n_pass++;
    @(negedge clk_h);
  endtask

  task automatic test_stall();
    offer(10'h057, 4'hF, 4'd3, good_par(10'h057));
    push_op(10'h057, 4'hF, 4'd3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_h);
      if (c == 1 || c == 2 || c == 5 || c == 6) begin
        exp_v = sb.pop_front();
        n_checks++;
        if (act_vec() !== exp_v) $display("FAIL stall_c%0d act=%h exp=%h", c, act_vec(), exp_v);
        else n_pass++;
      end else if (c == 3 || c == 4) begin
        n_checks++;
        if ({opc_ready_h, act_vec()} !== {1'b0, exp_v})
          $display("FAIL stall_hold%0d act=%h exp=%h", c, {opc_ready_h, act_vec()}, {1'b0, exp_v});
        else n_pass++;
      end else begin
        n_checks++;
        if (act_vec() !== IDLE_V) $display("FAIL stall_end act=%h exp=%h", act_vec(), IDLE_V);
        else n_pass++;
      end
      case (c)
        1: idle_in();
        2: stall_h = 1'b1;
        3: offer(10'h24A, 4'hF, 4'd0, good_par(10'h24A));
        4: begin stall_h = 1'b0; idle_in(); end
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    offer(10'h047, 4'hF, 4'd0, good_par(10'h047));
    push_op(10'h047, 4'hF, 4'd0);
    @(negedge clk_h);
    exp_v = sb.pop_front();
    n_checks++;
    if ({opc_ready_h, act_vec()} !== {1'b1, exp_v})
      $display("FAIL b2b_first act=%h exp=%h", {opc_ready_h, act_vec()}, {1'b1, exp_v});
    else n_pass++;
    offer(10'h24A, 4'hF, 4'd0, good_par(10'h24A));
    push_op(10'h24A, 4'hF, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if ({opc_ready_h, act_vec()} !== {1'b1, exp_v})
      $display("FAIL b2b_second act=%h exp=%h", {opc_ready_h, act_vec()}, {1'b1, exp_v});
    else n_pass++;
    @(negedge clk_h);
    n_checks++;
    if (act_vec() !== IDLE_V) $display("FAIL b2b_idle act=%h exp=%h", act_vec(), IDLE_V);
    else n_pass++;
  endtask

  task automatic test_max_rep();
    offer(10'h047, 4'hA, 4'd15, good_par(10'h047));
    push_op(10'h047, 4'hA, 4'd15);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_h);
      idle_in();
      exp_v = sb.pop_front();
      n_checks++;
      if (act_vec() !== exp_v) $display("FAIL maxrep_c%0d act=%h exp=%h", i, act_vec(), exp_v);
      else n_pass++;
    end
    @(negedge clk_h);
    n_checks++;
    if (act_vec() !== IDLE_V) $display("FAIL maxrep_idle act=%h exp=%h", act_vec(), IDLE_V);
    else n_pass++;
    offer(10'h24A, 4'h0, 4'd1, good_par(10'h24A));
    push_op(10'h24A, 4'h0, 4'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_h);
      idle_in();
      exp_v = sb.pop_front();
      n_checks++;
      if (act_vec() !== exp_v) $display("FAIL mask0_c%0d act=%h exp=%h", i, act_vec(), exp_v);
      else n_pass++;
    end
    @(negedge clk_h);
  endtask

  task automatic test_reset_midop();
    offer(10'h047, 4'hF, 4'd15, good_par(10'h047));
    push_op(10'h047, 4'hF, 4'd15);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_h);
      idle_in();
      exp_v = sb.pop_front();
      n_checks++;
      if (act_vec() !== exp_v) $display("FAIL midop_c%0d act=%h exp=%h", i, act_vec(), exp_v);
      else n_pass++;
    end
    #2 reset_h = 1'b1;
    #1;
    n_checks++;
    if ({opc_ready_h, act_vec()} !== {1'b1, IDLE_V})
      $display("FAIL midop_abort act=%h exp=%h", {opc_ready_h, act_vec()}, {1'b1, IDLE_V});
    else n_pass++;
    sb.delete();
    @(negedge clk_h);
    reset_h = 1'b0;
    @(negedge clk_h);
    n_checks++;
    if ({opc_ready_h, act_vec()} !== {1'b1, IDLE_V})
      $display("FAIL midop_after act=%h exp=%h", {opc_ready_h, act_vec()}, {1'b1, IDLE_V});
    else n_pass++;
  endtask

  task automatic test_parity();
`ifdef ALPCTL_SEQ_PARITY_EN
    offer(10'h047, 4'hF, 4'd0, 1'b0);
    push_op(10'h047, 4'h0, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if ({perr_h, act_vec()} !== {1'b1, exp_v})
      $display("FAIL parity_bad act=%h exp=%h", {perr_h, act_vec()}, {1'b1, exp_v});
    else n_pass++;
    offer(10'h047, 4'hF, 4'd0, 1'b1);
    push_op(10'h047, 4'hF, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if ({perr_h, act_vec()} !== {1'b1, exp_v})
      $display("FAIL parity_sticky act=%h exp=%h", {perr_h, act_vec()}, {1'b1, exp_v});
    else n_pass++;
`else
    offer(10'h047, 4'hF, 4'd0, 1'b0);
    push_op(10'h047, 4'hF, 4'd0);
    @(negedge clk_h);
    idle_in();
    exp_v = sb.pop_front();
    n_checks++;
    if ({perr_h, act_vec()} !== {1'b0, exp_v})
      $display("FAIL parity_off act=%h exp=%h", {perr_h, act_vec()}, {1'b0, exp_v});
    else n_pass++;
`endif
    @(negedge clk_h);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_pass_a();
    test_stall();
    test_back_to_back();
    test_max_rep();
    test_reset_midop();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
